// File: rtl/frag_attr_interp_pipe.sv
// rtl/frag_attr_interp_pipe.sv - pipelined barycentric attribute interpolator, one attribute per cycle
// Optional flat shading / provoking-vertex select is built only when FRAG_INTERP_FLAT_EN is defined.
module frag_attr_interp_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int W_FRAC     = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  input  logic [W_FRAC:0]       w0,
  input  logic [W_FRAC:0]       w1,
  input  logic [W_FRAC:0]       w2,
  input  logic [ADDR_WIDTH-1:0] first_attr,
  input  logic [ADDR_WIDTH-1:0] last_attr,
  input  logic                  flat,
  input  logic [1:0]            provoke_sel,
  output logic                  vert_rd_en,
  output logic [ADDR_WIDTH-1:0] vert_rd_addr,
  input  logic [DATA_WIDTH-1:0] vert_rd_data0,
  input  logic [DATA_WIDTH-1:0] vert_rd_data1,
  input  logic [DATA_WIDTH-1:0] vert_rd_data2,
  output logic                  frag_wr_en,
  output logic [ADDR_WIDTH-1:0] frag_wr_addr,
  output logic [DATA_WIDTH-1:0] frag_wr_data
);
  localparam int SW = DATA_WIDTH + W_FRAC + 3;
  localparam logic signed [SW-1:0] RND     = {{(SW-W_FRAC){1'b0}}, 1'b1, {(W_FRAC-1){1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] cnt, last_q;
  logic [W_FRAC:0]       w0_q, w1_q, w2_q;
  logic [RD_LATENCY-1:0] trk_v;
  logic [ADDR_WIDTH-1:0] trk_a [RD_LATENCY];
  logic signed [SW-1:0]  sum, shifted;
  logic [DATA_WIDTH-1:0] interp, result_d;

  function automatic logic signed [SW-1:0] mul_w(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [W_FRAC:0] w);
    logic signed [SW-1:0] ae, we;
    ae = $signed({{(SW-DATA_WIDTH){a[DATA_WIDTH-1]}}, a});
    we = $signed({{(SW-W_FRAC-1){1'b0}}, w});
    return ae * we;
  endfunction

  assign ready        = (state == IDLE);
  assign vert_rd_en   = (state == ISSUE);
  assign vert_rd_addr = cnt;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = (first_attr <= last_attr) ? ISSUE : DRAIN;
      ISSUE:   if (cnt == last_q) state_d = DRAIN;
      DRAIN:   if (trk_v == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Blend at full width, round half up, then clamp to the signed attribute range.
  always_comb begin
    sum     = mul_w(vert_rd_data0, w0_q) + mul_w(vert_rd_data1, w1_q) + mul_w(vert_rd_data2, w2_q) + RND;
    shifted = sum >>> W_FRAC;
    if (shifted > SAT_MAX)      interp = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) interp = SAT_MIN[DATA_WIDTH-1:0];
    else                        interp = shifted[DATA_WIDTH-1:0];
  end

`ifdef FRAG_INTERP_FLAT_EN
  logic       flat_q;
  logic [1:0] provoke_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flat_q    <= 1'b0;
      provoke_q <= 2'd0;
    end else if (state == IDLE && start) begin
      flat_q    <= flat;
      provoke_q <= provoke_sel;
    end
  end

  always_comb begin
    result_d = interp;
    if (flat_q) begin
      case (provoke_q)
        2'd0:    result_d = vert_rd_data0;
        2'd1:    result_d = vert_rd_data1;
        default: result_d = vert_rd_data2;
      endcase
    end
  end
`else
  logic unused_flat;
  assign unused_flat = ^{flat, provoke_sel};
  assign result_d    = interp;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      last_q       <= '0;
      w0_q         <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      trk_v        <= '0;
      for (int i = 0; i < RD_LATENCY; i++) trk_a[i] <= '0;
      done         <= 1'b0;
      frag_wr_en   <= 1'b0;
      frag_wr_addr <= '0;
      frag_wr_data <= '0;
    end else begin
      state <= state_d;
      done  <= (state == DRAIN) && (state_d == IDLE);
      if (state == IDLE && start) begin
        cnt    <= first_attr;
        last_q <= last_attr;
        w0_q   <= w0;
        w1_q   <= w1;
        w2_q   <= w2;
      end else if (state == ISSUE && cnt != last_q) begin
        cnt <= cnt + 1'b1;
      end
      // Tracking shift register: its tail lines up with the memory's returned data.
      trk_v[0] <= (state == ISSUE);
      trk_a[0] <= cnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        trk_v[i] <= trk_v[i-1];
        trk_a[i] <= trk_a[i-1];
      end
      frag_wr_en <= trk_v[RD_LATENCY-1];
      if (trk_v[RD_LATENCY-1]) begin
        frag_wr_addr <= trk_a[RD_LATENCY-1];
        frag_wr_data <= result_d;
      end
    end
  end
endmodule
